// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution unit: ARM condition codes,
// NZCV bit positions and the IT slot-condition helper.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // An else-slot flips only the low bit, which toggles each condition with its complement.
    function automatic logic [3:0] it_slot_cond(input logic [3:0] base, input logic inv);
        return {base[3:1], base[0] ^ inv};
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator; NV and any unused code yield 0.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // Decode the condition against the flag snapshot.
    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_it.sv
// Conditional-execution unit: banked NZCV flags, IT predication window and
// write-enable gating between decoder and datapath.
//
// window | meaning
// idle   | cnt_q == 0, instructions use their own cond field
// open   | cnt_q != 0, instructions use it_cond_q with the current else bit
module cond_unit_it
    import cond_pkg::*;
#(
    parameter int NBANK  = 2,
    parameter int IT_MAX = 4,
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int LW    = $clog2(IT_MAX + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [3:0]        cond_i,
    input  logic              pcs_i,
    input  logic              reg_w_i,
    input  logic              mem_w_i,
    input  logic              no_write_i,
    input  logic [1:0]        flag_w_i,
    input  logic [BW-1:0]     bank_sel_i,
    input  logic [3:0]        alu_flag_i,
    input  logic              it_start_i,
    input  logic [LW-1:0]     it_len_i,
    input  logic [IT_MAX-1:0] it_mask_i,
    output logic              pc_src_o,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              cond_ex_o,
    output logic [3:0]        flags_o,
    output logic              it_active_o,
    output logic              it_err_o
);

    logic [3:0]        flag_q [NBANK];
    logic [3:0]        flag_d [NBANK];
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [IT_MAX-1:0] pat_q, pat_d;
    logic [3:0]        it_cond_q, it_cond_d;

    logic [3:0] flags_rd;
    logic [3:0] ec;
    logic       pass;
    logic       kill, g, len_ok, start_ok, wr;

    // Read mux for the selected flag bank; out-of-range selects read zero.
    always_comb begin
        flags_rd = 4'b0000;
        for (int b = 0; b < NBANK; b++) begin
            if (bank_sel_i == BW'(b)) flags_rd = flag_q[b];
        end
    end

    assign flags_o     = flags_rd;
    assign it_active_o = (cnt_q != '0);
    assign ec          = it_active_o ? it_slot_cond(it_cond_q, pat_q[0]) : cond_i;

    cond_eval u_eval (
        .cond_i  (ec),
        .flags_i (flags_rd),
        .pass_o  (pass)
    );

    assign kill        = flush_i | reset_i;
    assign g           = valid_i & ~kill;
    assign len_ok      = (it_len_i != '0) && (it_len_i <= LW'(IT_MAX));
    assign start_ok    = it_start_i & ~it_active_o & len_ok;
    assign cond_ex_o   = ~kill & (start_ok | pass);
    // IT instructions, legal or not, never write anything themselves.
    assign wr          = g & cond_ex_o & ~it_start_i;
    assign pc_src_o    = wr & pcs_i;
    assign reg_write_o = wr & reg_w_i & ~no_write_i;
    assign mem_write_o = wr & mem_w_i;
    assign it_err_o    = g & it_start_i & ~start_ok;

    // Next-state for flag banks and the IT window.
    always_comb begin
        flag_d    = flag_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        it_cond_d = it_cond_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (valid_i) begin
            for (int b = 0; b < NBANK; b++) begin
                if (wr && bank_sel_i == BW'(b)) begin
                    if (flag_w_i[1]) flag_d[b][3:2] = alu_flag_i[3:2];
                    if (flag_w_i[0]) flag_d[b][1:0] = alu_flag_i[1:0];
                end
            end
            if (it_active_o) begin
                cnt_d = pc_src_o ? '0 : cnt_q - LW'(1);
                pat_d = pat_q >> 1;
            end else if (start_ok) begin
                cnt_d     = it_len_i;
                pat_d     = it_mask_i;
                it_cond_d = cond_i;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int b = 0; b < NBANK; b++) flag_q[b] <= 4'b0000;
            cnt_q     <= '0;
            pat_q     <= '0;
            it_cond_q <= 4'b0000;
        end else begin
            for (int b = 0; b < NBANK; b++) flag_q[b] <= flag_d[b];
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            it_cond_q <= it_cond_d;
        end
    end

endmodule
